// File: rtl/dm_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter_pkg
// Shared constants for the data-memory port arbiter and its neighbours:
//   - default highest legal byte address of the data RAM
//   - port index constants (CPU MEM stage = 0, debug/program-load bridge = 1)
//   - byte-enable patterns produced by the MEM-stage store formatter
//   - small helper to build a one-hot port grant from a port index
// -----------------------------------------------------------------------------
package dm_port_arbiter_pkg;

    localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_1fff;

    localparam int PORT_CPU = 0;
    localparam int PORT_BRG = 1;

    // Byte-enable patterns emitted by the store formatter (already lane aligned).
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a bounded lock.
//   clk, reset : clock, asynchronous active-low reset
//   req[1:0]   : per-port request
//   lock[1:0]  : per-port lock; only matters while that port holds the grant
//   gnt[1:0]   : one-hot grant, combinational, same cycle as req
// State: last_gnt (index of the most recently granted port) and lock_cnt
// (number of consecutive locked grants to last_gnt; nonzero means the
// previous cycle was a locked grant to that port).
// -----------------------------------------------------------------------------
module rr_arb2
    import dm_port_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    logic       last_gnt;
    logic [7:0] lock_cnt;
    logic       hold;
    logic       win;
    logic       any_req;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block can leave a value unassigned and infer a latch.
        win     = 1'b0;
        any_req = |req;
        // The lock holds only while the holder keeps req and lock high and
        // has not yet used up its LOCK_MAX consecutive grants.
        hold    = (lock_cnt != 8'd0) && (lock_cnt < LOCK_MAX_C)
                  && req[last_gnt] && lock[last_gnt];
        if (hold) begin
            win = last_gnt;
        end else if (&req) begin
            win = ~last_gnt;
        end else begin
            win = req[1];
        end
        gnt = any_req ? port_onehot(win) : 2'b00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= 1'b1;           // port 0 wins the first contention
            lock_cnt <= 8'd0;
        end else if (any_req) begin
            last_gnt <= win;
            if (lock[win]) begin
                // A fresh lock (port change or forced release) restarts at 1.
                lock_cnt <= hold ? lock_cnt + 8'd1 : 8'd1;
            end else begin
                lock_cnt <= 8'd0;
            end
        end else begin
            lock_cnt <= 8'd0;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
// Shares the single-port data-memory block RAM between the CPU MEM stage
// (port 0) and the debug/program-load bridge (port 1).
//   clk, reset      : clock, asynchronous active-low reset
//   req/lock/we[1:0]: per-port request, lock, store flag
//   addr[63:0]      : byte addresses {port1, port0}
//   be[7:0]         : byte enables {port1, port0}
//   wdata[63:0]     : lane-replicated write data {port1, port0}
//   gnt[1:0]        : one-hot grant, combinational
//   rvalid[1:0]     : one-hot response strobe for the previous cycle's grant
//   rdata[31:0]     : load data (0 for stores and out-of-range accesses)
//   err             : out-of-range flag, qualified by rvalid
//   mem_we/mem_addr/mem_wdata/mem_rdata : block RAM port (1-cycle read)
// -----------------------------------------------------------------------------
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF,
    parameter int          AW         = 11,
    parameter int          LOCK_MAX   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [1:0]    lock,
    input  logic [1:0]    we,
    input  logic [63:0]   addr,
    input  logic [7:0]    be,
    input  logic [63:0]   wdata,
    output logic [1:0]    gnt,
    output logic [1:0]    rvalid,
    output logic [31:0]   rdata,
    output logic          err,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    logic [1:0]    arb_gnt;
    logic          sel;
    logic          granted;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;
    logic          sel_we;
    logic          oor;
    logic [AW-1:0] addr_q;
    logic [1:0]    rsp_vld;
    logic          rsp_err;
    logic          rsp_load;

    rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .gnt   (arb_gnt)
    );

    // No grant is visible while reset is held, even with requests pending.
    assign gnt     = reset ? arb_gnt : 2'b00;
    assign granted = |gnt;
    assign sel     = gnt[PORT_BRG];

    assign sel_addr  = sel ? addr[63:32]  : addr[31:0];
    assign sel_wdata = sel ? wdata[63:32] : wdata[31:0];
    assign sel_be    = sel ? be[7:4]      : be[3:0];
    assign sel_we    = sel ? we[PORT_BRG] : we[PORT_CPU];

    assign oor = sel_addr > ADDR_LIMIT;

    // Out-of-range accesses still consume the slot but never write the RAM.
    assign mem_we    = (granted && sel_we && !oor) ? sel_be : 4'b0000;
    // Idle cycles hold the last address so the RAM address bus stays quiet.
    assign mem_addr  = granted ? sel_addr[AW+1:2] : addr_q;
    assign mem_wdata = sel_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            rsp_vld  <= 2'b00;
            rsp_err  <= 1'b0;
            rsp_load <= 1'b0;
        end else begin
            if (granted) begin
                addr_q <= sel_addr[AW+1:2];
            end
            rsp_vld  <= gnt;
            rsp_err  <= granted && oor;
            rsp_load <= granted && !oor && !sel_we;
        end
    end

    assign rvalid = rsp_vld;
    assign err    = rsp_err;
    // The RAM output is already aligned with the response cycle.
    assign rdata  = rsp_load ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
// Directed bench for dm_port_arbiter with a behavioural byte-write block RAM.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    lock;
    logic [1:0]    we;
    logic [63:0]   addr;
    logic [7:0]    be;
    logic [63:0]   wdata;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [31:0]   rdata;
    logic          err;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dm_port_arbiter #(
        .ADDR_LIMIT (32'h0000_1fff),
        .AW         (AW),
        .LOCK_MAX   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .be        (be),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Block RAM model: byte writes, read-first, one-cycle read latency.
    logic [31:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    we;
        logic [31:0]   a0;
        logic [31:0]   a1;
        logic [3:0]    b0;
        logic [3:0]    b1;
        logic [31:0]   w0;
        logic [31:0]   w1;
        logic [1:0]    x_gnt;
        logic [3:0]    x_mwe;
        logic [AW-1:0] x_maddr;
        logic          chk_addr;
        logic [1:0]    x_rv;
        logic          x_err;
        logic [31:0]   x_rd;
        logic          chk_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic [1:0] req_i, input logic [1:0] we_i,
        input logic [31:0] a0_i, input logic [31:0] a1_i,
        input logic [3:0] b0_i, input logic [3:0] b1_i,
        input logic [31:0] w0_i, input logic [31:0] w1_i,
        input logic [1:0] gnt_i, input logic [3:0] mwe_i,
        input logic [AW-1:0] maddr_i, input logic chka_i,
        input logic [1:0] rv_i, input logic err_i,
        input logic [31:0] rd_i, input logic chkrd_i);
        vec_t v;
        v.req = req_i;     v.we = we_i;
        v.a0 = a0_i;       v.a1 = a1_i;
        v.b0 = b0_i;       v.b1 = b1_i;
        v.w0 = w0_i;       v.w1 = w1_i;
        v.x_gnt = gnt_i;   v.x_mwe = mwe_i;
        v.x_maddr = maddr_i; v.chk_addr = chka_i;
        v.x_rv = rv_i;     v.x_err = err_i;
        v.x_rd = rd_i;     v.chk_rd = chkrd_i;
        return v;
    endfunction

    vec_t vecs [21];

    initial begin
        logic [1:0]  x_g;
        logic [1:0]  prev_g;
        logic [31:0] x_wd;

        //                 req    we     a0            a1            b0       b1       w0            w1             gnt    mwe      maddr   ca    rv     err   rdata         cr
        vecs[0]  = mk(2'b11, 2'b00, 32'h10,       32'h20,       4'h0,    4'h0,    32'h0,        32'h0,         2'b01, 4'h0,    11'h004, 1'b1, 2'b00, 1'b0, 32'h0,        1'b0);
        vecs[1]  = mk(2'b11, 2'b00, 32'h10,       32'h20,       4'h0,    4'h0,    32'h0,        32'h0,         2'b10, 4'h0,    11'h008, 1'b1, 2'b01, 1'b0, 32'h0,        1'b1);
        vecs[2]  = mk(2'b01, 2'b01, 32'h12,       32'h0,        4'b0100, 4'h0,    32'hABABABAB, 32'h0,         2'b01, 4'b0100, 11'h004, 1'b1, 2'b10, 1'b0, 32'h0,        1'b1);
        vecs[3]  = mk(2'b00, 2'b00, 32'h0,        32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b00, 4'h0,    11'h004, 1'b1, 2'b01, 1'b0, 32'h0,        1'b1);
        vecs[4]  = mk(2'b01, 2'b00, 32'h10,       32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b01, 4'h0,    11'h004, 1'b1, 2'b00, 1'b0, 32'h0,        1'b0);
        vecs[5]  = mk(2'b00, 2'b00, 32'h0,        32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b00, 4'h0,    11'h004, 1'b1, 2'b01, 1'b0, 32'h00AB0000, 1'b1);
        vecs[6]  = mk(2'b11, 2'b00, 32'h10,       32'h14,       4'h0,    4'h0,    32'h0,        32'h0,         2'b10, 4'h0,    11'h005, 1'b1, 2'b00, 1'b0, 32'h0,        1'b0);
        vecs[7]  = mk(2'b11, 2'b00, 32'h10,       32'h14,       4'h0,    4'h0,    32'h0,        32'h0,         2'b01, 4'h0,    11'h004, 1'b1, 2'b10, 1'b0, 32'h0,        1'b1);
        vecs[8]  = mk(2'b11, 2'b00, 32'h10,       32'h14,       4'h0,    4'h0,    32'h0,        32'h0,         2'b10, 4'h0,    11'h005, 1'b1, 2'b01, 1'b0, 32'h00AB0000, 1'b1);
        vecs[9]  = mk(2'b11, 2'b00, 32'h10,       32'h14,       4'h0,    4'h0,    32'h0,        32'h0,         2'b01, 4'h0,    11'h004, 1'b1, 2'b10, 1'b0, 32'h0,        1'b1);
        vecs[10] = mk(2'b10, 2'b10, 32'h0,        32'h14,       4'h0,    4'hF,    32'h0,        32'h12345678,  2'b10, 4'hF,    11'h005, 1'b1, 2'b01, 1'b0, 32'h00AB0000, 1'b1);
        vecs[11] = mk(2'b01, 2'b00, 32'h2000,     32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b01, 4'h0,    11'h000, 1'b0, 2'b10, 1'b0, 32'h0,        1'b1);
        vecs[12] = mk(2'b01, 2'b01, 32'h1fff,     32'h0,        4'b1000, 4'h0,    32'hCDCDCDCD, 32'h0,         2'b01, 4'b1000, 11'h7ff, 1'b1, 2'b01, 1'b1, 32'h0,        1'b1);
        vecs[13] = mk(2'b10, 2'b10, 32'h0,        32'h2000,     4'h0,    4'hF,    32'h0,        32'hFFFFFFFF,  2'b10, 4'h0,    11'h000, 1'b0, 2'b01, 1'b0, 32'h0,        1'b1);
        vecs[14] = mk(2'b00, 2'b00, 32'h0,        32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b00, 4'h0,    11'h000, 1'b0, 2'b10, 1'b1, 32'h0,        1'b1);
        vecs[15] = mk(2'b01, 2'b00, 32'h1ffc,     32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b01, 4'h0,    11'h7ff, 1'b1, 2'b00, 1'b0, 32'h0,        1'b0);
        vecs[16] = mk(2'b00, 2'b00, 32'h0,        32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b00, 4'h0,    11'h7ff, 1'b1, 2'b01, 1'b0, 32'hCD000000, 1'b1);
        vecs[17] = mk(2'b01, 2'b01, 32'h10,       32'h0,        4'b0001, 4'h0,    32'h11111111, 32'h0,         2'b01, 4'b0001, 11'h004, 1'b1, 2'b00, 1'b0, 32'h0,        1'b0);
        vecs[18] = mk(2'b00, 2'b00, 32'h0,        32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b00, 4'h0,    11'h004, 1'b1, 2'b01, 1'b0, 32'h0,        1'b1);
        vecs[19] = mk(2'b01, 2'b00, 32'h10,       32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b01, 4'h0,    11'h004, 1'b1, 2'b00, 1'b0, 32'h0,        1'b0);
        vecs[20] = mk(2'b00, 2'b00, 32'h0,        32'h0,        4'h0,    4'h0,    32'h0,        32'h0,         2'b00, 4'h0,    11'h004, 1'b1, 2'b01, 1'b0, 32'h00AB0011, 1'b1);

        // ---- Reset held low with both ports requesting ----
        reset = 1'b0;
        req = 2'b11; lock = 2'b00; we = 2'b00;
        addr = {32'h20, 32'h10}; be = 8'h00; wdata = 64'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset c%0d gnt", c), 32'(gnt), 32'(2'b00));
            check($sformatf("reset c%0d rvalid", c), 32'(rvalid), 32'(2'b00));
        end
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        check("reset err", 32'(err), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // ---- Table-driven vectors, one per cycle ----
        for (int i = 0; i < 21; i++) begin
            req   = vecs[i].req;
            we    = vecs[i].we;
            addr  = {vecs[i].a1, vecs[i].a0};
            be    = {vecs[i].b1, vecs[i].b0};
            wdata = {vecs[i].w1, vecs[i].w0};
            @(negedge clk);
            check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].x_gnt));
            check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].x_mwe));
            if (vecs[i].chk_addr)
                check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].x_maddr));
            if (vecs[i].x_mwe != 4'h0) begin
                x_wd = vecs[i].x_gnt[1] ? vecs[i].w1 : vecs[i].w0;
                check($sformatf("v%0d mem_wdata", i), mem_wdata, x_wd);
            end
            check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].x_rv));
            if (vecs[i].x_rv != 2'b00)
                check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].x_err));
            if (vecs[i].chk_rd)
                check($sformatf("v%0d rdata", i), rdata, vecs[i].x_rd);
            @(posedge clk); #1;
        end

        // ---- Lock: port 1 locks while port 0 keeps requesting ----
        // Port 0 was granted last, so port 1 takes the first slot, keeps it
        // for 8 grants, yields one slot to port 0, then locks again.
        req = 2'b11; lock = 2'b10; we = 2'b00;
        addr = {32'h14, 32'h10}; be = 8'h00; wdata = 64'h0;
        prev_g = 2'b00;
        for (int i = 0; i < 11; i++) begin
            x_g = (i == 8) ? 2'b01 : 2'b10;
            @(negedge clk);
            check($sformatf("lock c%0d gnt", i), 32'(gnt), 32'(x_g));
            check($sformatf("lock c%0d rvalid", i), 32'(rvalid), 32'(prev_g));
            prev_g = x_g;
            @(posedge clk); #1;
        end

        // Lock dropped: plain alternation resumes with port 0.
        lock = 2'b00;
        @(negedge clk);
        check("unlock gnt0", 32'(gnt), 32'(2'b01));
        @(posedge clk); #1;
        @(negedge clk);
        check("unlock gnt1", 32'(gnt), 32'(2'b10));
        check("unlock rvalid", 32'(rvalid), 32'(2'b01));
        @(posedge clk); #1;

        // ---- Reset during the response cycle of a granted load ----
        req = 2'b01; addr = {32'h0, 32'h10};
        @(negedge clk);
        check("rstmid grant", 32'(gnt), 32'(2'b01));
        @(posedge clk); #1;
        reset = 1'b0;
        req = 2'b00;
        @(negedge clk);
        check("rstmid rvalid in reset", 32'(rvalid), 32'(2'b00));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        req = 2'b11; addr = {32'h14, 32'h10};
        @(negedge clk);
        check("rstmid rvalid after release", 32'(rvalid), 32'(2'b00));
        check("rstmid first gnt", 32'(gnt), 32'(2'b01));
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        check("rstmid next rvalid", 32'(rvalid), 32'(2'b01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
